// File: rtl/pipeline_pkg.sv
// rtl/pipeline_pkg.sv - shared types and constants for the address pipeline
//
// Purpose: arbiter FSM encoding, burst counter width, and the global
// address/id widths re-exported as package parameters.
`include "defines.vh"

package pipeline_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    STREAM  = 2'd1,
    BLOCKED = 2'd2
  } arb_state_t;

  localparam int BURST_CNT_W = 8;
  localparam int ADDR_W      = `ADDRESS_WIDTH;
  localparam int ID_W        = `ID_WIDTH;

endpackage

// File: rtl/defines.vh
// rtl/defines.vh - global address and id widths shared by the pipeline blocks
`ifndef PIPELINE_DEFINES_VH
`define PIPELINE_DEFINES_VH

`define ADDRESS_WIDTH 16
`define ID_WIDTH 4

`endif

// File: rtl/rr_priority_pick.sv
// rtl/rr_priority_pick.sv - combinational round-robin first-set-bit picker
//
// Purpose: find the first set bit of req searching upward from ptr, wrapping.
// Ports:
//   req   in  NUM_REQ  request vector
//   ptr   in  PTR_W    search start index (must be < NUM_REQ)
//   grant out NUM_REQ  one-hot winner (all zero when nothing requested)
//   idx   out PTR_W    binary winner index (0 when nothing requested)
//   any   out 1        at least one request present
module rr_priority_pick #(
  parameter int NUM_REQ = 4,
  parameter int PTR_W   = $clog2(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [PTR_W-1:0]   ptr,
  output logic [NUM_REQ-1:0] grant,
  output logic [PTR_W-1:0]   idx,
  output logic               any
);

  // One extra bit so ptr + offset can reach 2*NUM_REQ-2 before the wrap.
  localparam int SUM_W = PTR_W + 1;

  logic [SUM_W-1:0] sum;
  logic [PTR_W-1:0] cand;

  always_comb begin
    grant = '0;
    idx   = '0;
    any   = 1'b0;
    sum   = '0;
    cand  = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      sum = {1'b0, ptr} + SUM_W'(i);
      // Single conditional subtract is enough since both terms are < NUM_REQ.
      if (sum >= SUM_W'(NUM_REQ)) begin
        cand = PTR_W'(sum - SUM_W'(NUM_REQ));
      end else begin
        cand = PTR_W'(sum);
      end
      if (!any && req[cand]) begin
        any         = 1'b1;
        grant[cand] = 1'b1;
        idx         = cand;
      end
    end
  end

endmodule

// File: rtl/pipeline_ingress_arbiter.sv
// rtl/pipeline_ingress_arbiter.sv - round-robin burst arbiter feeding the pipeline head
//
// Purpose: shares the pipeline head between NUM_REQ requesters with a
// per-owner burst allowance, an enable mask and a source tag, behind one
// registered output slot.
// Ports:
//   clk, reset_n           clock, asynchronous active-low reset
//   req_enable/req_valid   per-requester mask and valid
//   req_address/req_id     flattened per-requester payload, slice i = requester i
//   req_stall              1 = requester not accepted this cycle, hold data
//   out_address/out_id     registered payload to the pipeline head
//   out_src/out_valid      winning requester index, slot occupied
//   in_stall               stall from the pipeline head
//   state                  debug view of the FSM
module pipeline_ingress_arbiter
  import pipeline_pkg::*;
#(
  parameter int NUM_REQ   = 4,
  parameter int BURST_LEN = 4,
  parameter int SRC_WIDTH = $clog2(NUM_REQ)
) (
  input  logic                      clk,
  input  logic                      reset_n,
  input  logic [NUM_REQ-1:0]        req_enable,
  input  logic [NUM_REQ-1:0]        req_valid,
  input  logic [NUM_REQ*ADDR_W-1:0] req_address,
  input  logic [NUM_REQ*ID_W-1:0]   req_id,
  output logic [NUM_REQ-1:0]        req_stall,
  output logic [ADDR_W-1:0]         out_address,
  output logic [ID_W-1:0]           out_id,
  output logic [SRC_WIDTH-1:0]      out_src,
  output logic                      out_valid,
  input  logic                      in_stall,
  output logic [1:0]                state
);

  logic [NUM_REQ-1:0]   elig;
  logic [NUM_REQ-1:0]   grant;
  logic [SRC_WIDTH-1:0] win;
  logic                 any;
  logic                 load_en;
  logic                 accept;
  logic                 burst_done;

  logic [SRC_WIDTH-1:0]   ptr_q, ptr_d;
  logic [SRC_WIDTH-1:0]   owner_q, owner_d;
  logic [BURST_CNT_W-1:0] burst_cnt_q, burst_cnt_d;
  logic [ADDR_W-1:0]      out_address_q, out_address_d;
  logic [ID_W-1:0]        out_id_q, out_id_d;
  logic [SRC_WIDTH-1:0]   out_src_q, out_src_d;
  logic                   out_valid_q, out_valid_d;
  arb_state_t             state_q, state_d;

  function automatic logic [SRC_WIDTH-1:0] next_idx(input logic [SRC_WIDTH-1:0] i);
    return (i == SRC_WIDTH'(NUM_REQ - 1)) ? '0 : i + SRC_WIDTH'(1);
  endfunction

  assign elig    = req_valid & req_enable;
  assign load_en = !(in_stall && out_valid_q);
  assign accept  = load_en && any;

  rr_priority_pick #(
    .NUM_REQ (NUM_REQ),
    .PTR_W   (SRC_WIDTH)
  ) u_pick (
    .req   (elig),
    .ptr   (ptr_q),
    .grant (grant),
    .idx   (win),
    .any   (any)
  );

  // reset_n gates the stall so nothing looks accepted while the flops are held.
  assign req_stall = (reset_n && accept) ? ~grant : '1;

  // Output slot: reloads whenever not held; an empty pick drains it.
  always_comb begin
    out_valid_d   = out_valid_q;
    out_address_d = out_address_q;
    out_id_d      = out_id_q;
    out_src_d     = out_src_q;
    if (load_en) begin
      out_valid_d = any;
      if (any) begin
        out_src_d = win;
        for (int i = 0; i < NUM_REQ; i++) begin
          if (grant[i]) begin
            out_address_d = req_address[i*ADDR_W +: ADDR_W];
            out_id_d      = req_id[i*ID_W +: ID_W];
          end
        end
      end
    end
  end

  assign burst_done = ({1'b0, burst_cnt_q} + (BURST_CNT_W+1)'(1)) >= (BURST_CNT_W+1)'(BURST_LEN);

  // Burst tracking: ptr parks on the owner until its allowance is spent.
  // Any cycle without an accept ends the burst but leaves priority alone.
  always_comb begin
    ptr_d       = ptr_q;
    owner_d     = owner_q;
    burst_cnt_d = burst_cnt_q;
    if (accept) begin
      if (win == owner_q) begin
        if (burst_done) begin
          ptr_d       = next_idx(win);
          burst_cnt_d = '0;
        end else begin
          ptr_d       = win;
          burst_cnt_d = burst_cnt_q + BURST_CNT_W'(1);
        end
      end else begin
        owner_d     = win;
        burst_cnt_d = BURST_CNT_W'(1);
        ptr_d       = (BURST_LEN == 1) ? next_idx(win) : win;
      end
    end else begin
      burst_cnt_d = '0;
    end
  end

  // FSM tracks what the slot will hold next cycle.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: begin
        if (accept) state_d = STREAM;
      end
      STREAM: begin
        if (!load_en)     state_d = BLOCKED;
        else if (!accept) state_d = IDLE;
      end
      BLOCKED: begin
        if (load_en) state_d = accept ? STREAM : IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      ptr_q         <= '0;
      owner_q       <= '0;
      burst_cnt_q   <= '0;
      out_address_q <= '0;
      out_id_q      <= '0;
      out_src_q     <= '0;
      out_valid_q   <= 1'b0;
      state_q       <= IDLE;
    end else begin
      ptr_q         <= ptr_d;
      owner_q       <= owner_d;
      burst_cnt_q   <= burst_cnt_d;
      out_address_q <= out_address_d;
      out_id_q      <= out_id_d;
      out_src_q     <= out_src_d;
      out_valid_q   <= out_valid_d;
      state_q       <= state_d;
    end
  end

  assign out_address = out_address_q;
  assign out_id      = out_id_q;
  assign out_src     = out_src_q;
  assign out_valid   = out_valid_q;
  assign state       = state_q;

endmodule

// File: tb/tb_pipeline_ingress_arbiter.sv
// tb/tb_pipeline_ingress_arbiter.sv - directed self-checking bench for the ingress arbiter
module tb_pipeline_ingress_arbiter;
  import pipeline_pkg::*;

  localparam int N = 4;

  logic                clk = 1'b0;
  logic                reset_n;
  logic                in_stall;
  logic [N-1:0]        req_enable;
  logic [N-1:0]        req_valid;
  logic [N*ADDR_W-1:0] req_address;
  logic [N*ID_W-1:0]   req_id;

  // a: BURST_LEN=2, b: BURST_LEN=4, c: BURST_LEN=1; all share stimulus
  logic [N-1:0] a_stall, b_stall, c_stall;
  logic [ADDR_W-1:0] a_addr, b_addr, c_addr;
  logic [ID_W-1:0] a_id, b_id, c_id;
  logic [1:0] a_src, b_src, c_src;
  logic a_valid, b_valid, c_valid;
  logic [1:0] a_state, b_state, c_state;

  int tests = 0;
  int fails = 0;

  always #5 clk = ~clk;

  pipeline_ingress_arbiter #(.NUM_REQ(N), .BURST_LEN(2)) dut_a (
    .clk(clk), .reset_n(reset_n), .req_enable(req_enable), .req_valid(req_valid),
    .req_address(req_address), .req_id(req_id), .req_stall(a_stall),
    .out_address(a_addr), .out_id(a_id), .out_src(a_src), .out_valid(a_valid),
    .in_stall(in_stall), .state(a_state));

  pipeline_ingress_arbiter #(.NUM_REQ(N), .BURST_LEN(4)) dut_b (
    .clk(clk), .reset_n(reset_n), .req_enable(req_enable), .req_valid(req_valid),
    .req_address(req_address), .req_id(req_id), .req_stall(b_stall),
    .out_address(b_addr), .out_id(b_id), .out_src(b_src), .out_valid(b_valid),
    .in_stall(in_stall), .state(b_state));

  pipeline_ingress_arbiter #(.NUM_REQ(N), .BURST_LEN(1)) dut_c (
    .clk(clk), .reset_n(reset_n), .req_enable(req_enable), .req_valid(req_valid),
    .req_address(req_address), .req_id(req_id), .req_stall(c_stall),
    .out_address(c_addr), .out_id(c_id), .out_src(c_src), .out_valid(c_valid),
    .in_stall(in_stall), .state(c_state));

  task automatic step;
    @(posedge clk);
    #1;
  endtask

  task automatic set_req(input int i, input logic [ADDR_W-1:0] a, input logic [ID_W-1:0] d);
    req_address[i*ADDR_W +: ADDR_W] = a;
    req_id[i*ID_W +: ID_W]          = d;
  endtask

  task automatic do_reset;
    reset_n    = 1'b0;
    in_stall   = 1'b0;
    req_valid  = '0;
    req_enable = '1;
    step;
    reset_n = 1'b1;
  endtask

  task automatic test_reset;
    do_reset;
    req_valid = 4'b1111;
    step;
    tests++;
    if (a_valid !== 1'b1 || a_src !== 2'd0) begin
      fails++;
      $display("FAIL reset_prestream: valid=%0b src=%0d, required valid=1 src=0", a_valid, a_src);
    end
    reset_n = 1'b0;
    #1;
    tests++;
    if (a_valid !== 1'b0 || a_src !== 2'd0 || a_addr !== 16'h0 || a_id !== 4'h0 || a_state !== 2'd0) begin
      fails++;
      $display("FAIL reset_async: valid=%0b src=%0d addr=%h id=%h state=%0d, required all 0",
               a_valid, a_src, a_addr, a_id, a_state);
    end
    tests++;
    if (a_stall !== 4'b1111) begin
      fails++;
      $display("FAIL reset_stall: req_stall=%b, required 1111", a_stall);
    end
    step;
    tests++;
    if (a_valid !== 1'b0) begin
      fails++;
      $display("FAIL reset_held: valid=%0b, required 0", a_valid);
    end
    reset_n = 1'b1;
    #1;
    tests++;
    if (a_stall !== 4'b1110) begin
      fails++;
      $display("FAIL reset_first_pick: req_stall=%b, required 1110", a_stall);
    end
    step;
    tests++;
    if (a_valid !== 1'b1 || a_src !== 2'd0 || a_addr !== 16'h0100 || a_id !== 4'h1) begin
      fails++;
      $display("FAIL reset_first_accept: valid=%0b src=%0d addr=%h id=%h, required 1 0 0100 1",
               a_valid, a_src, a_addr, a_id);
    end
  endtask

  task automatic test_burst_rotation;
    int exp_src[9] = '{0, 0, 1, 1, 2, 2, 3, 3, 0};
    do_reset;
    req_valid = 4'b1111;
    for (int k = 0; k < 9; k++) begin
      step;
      tests++;
      if (a_valid !== 1'b1 || a_src !== 2'(exp_src[k]) || a_addr !== 16'(16'h0100 + exp_src[k])) begin
        fails++;
        $display("FAIL burst_seq[%0d]: valid=%0b src=%0d addr=%h, required 1 %0d %h",
                 k, a_valid, a_src, a_addr, exp_src[k], 16'(16'h0100 + exp_src[k]));
      end
    end
  endtask

  task automatic test_back_to_back;
    do_reset;
    req_valid = 4'b0010;
    for (int k = 0; k < 5; k++) begin
      step;
      tests++;
      if (a_valid !== 1'b1 || a_src !== 2'd1 || a_state !== 2'd1) begin
        fails++;
        $display("FAIL single_stream[%0d]: valid=%0b src=%0d state=%0d, required 1 1 1",
                 k, a_valid, a_src, a_state);
      end
    end
  endtask

  task automatic test_stall_hold;
    do_reset;
    set_req(2, 16'h001A, 4'h3);
    req_valid = 4'b0100;
    step;
    tests++;
    if (a_valid !== 1'b1 || a_src !== 2'd2 || a_addr !== 16'h001A || a_state !== 2'd1) begin
      fails++;
      $display("FAIL stall_load: valid=%0b src=%0d addr=%h state=%0d, required 1 2 001a 1",
               a_valid, a_src, a_addr, a_state);
    end
    in_stall = 1'b1;
    #1;
    tests++;
    if (a_stall !== 4'b1111) begin
      fails++;
      $display("FAIL stall_comb: req_stall=%b, required 1111", a_stall);
    end
    for (int k = 0; k < 3; k++) begin
      step;
      tests++;
      if (a_valid !== 1'b1 || a_src !== 2'd2 || a_addr !== 16'h001A || a_id !== 4'h3 ||
          a_state !== 2'd2 || a_stall !== 4'b1111) begin
        fails++;
        $display("FAIL stall_hold[%0d]: valid=%0b src=%0d addr=%h id=%h state=%0d stall=%b, required 1 2 001a 3 2 1111",
                 k, a_valid, a_src, a_addr, a_id, a_state, a_stall);
      end
    end
    in_stall = 1'b0;
    #1;
    tests++;
    if (a_stall !== 4'b1011) begin
      fails++;
      $display("FAIL stall_release: req_stall=%b, required 1011", a_stall);
    end
    step;
    tests++;
    if (a_state !== 2'd1 || a_valid !== 1'b1 || a_src !== 2'd2) begin
      fails++;
      $display("FAIL stall_resume: state=%0d valid=%0b src=%0d, required 1 1 2", a_state, a_valid, a_src);
    end
    set_req(2, 16'h0102, 4'h3);
  endtask

  task automatic test_mask_mid_burst;
    int exp_src[7] = '{1, 1, 2, 2, 2, 2, 3};
    do_reset;
    req_valid = 4'b1110;
    for (int k = 0; k < 7; k++) begin
      if (k == 2) req_enable = 4'b1101;
      step;
      tests++;
      if (b_valid !== 1'b1 || b_src !== 2'(exp_src[k])) begin
        fails++;
        $display("FAIL mask_seq[%0d]: valid=%0b src=%0d, required 1 %0d", k, b_valid, b_src, exp_src[k]);
      end
    end
    req_enable = '1;
  endtask

  task automatic test_drain;
    do_reset;
    req_valid = 4'b1111;
    step;
    req_valid = 4'b0000;
    #1;
    tests++;
    if (a_stall !== 4'b1111) begin
      fails++;
      $display("FAIL drain_stall: req_stall=%b, required 1111", a_stall);
    end
    step;
    tests++;
    if (a_valid !== 1'b0 || a_state !== 2'd0) begin
      fails++;
      $display("FAIL drain_idle: valid=%0b state=%0d, required 0 0", a_valid, a_state);
    end
    set_req(3, 16'h0103, 4'h5);
    req_valid = 4'b1000;
    #1;
    tests++;
    if (a_stall !== 4'b0111) begin
      fails++;
      $display("FAIL drain_wake_stall: req_stall=%b, required 0111", a_stall);
    end
    step;
    tests++;
    if (a_valid !== 1'b1 || a_id !== 4'h5 || a_src !== 2'd3 || a_state !== 2'd1) begin
      fails++;
      $display("FAIL drain_wake: valid=%0b id=%h src=%0d state=%0d, required 1 5 3 1",
               a_valid, a_id, a_src, a_state);
    end
  endtask

  task automatic test_pure_rr;
    int exp_src[6] = '{0, 3, 0, 3, 0, 3};
    do_reset;
    req_valid = 4'b1001;
    for (int k = 0; k < 6; k++) begin
      step;
      tests++;
      if (c_valid !== 1'b1 || c_src !== 2'(exp_src[k])) begin
        fails++;
        $display("FAIL rr_seq[%0d]: valid=%0b src=%0d, required 1 %0d", k, c_valid, c_src, exp_src[k]);
      end
    end
  endtask

  initial begin
    reset_n     = 1'b0;
    in_stall    = 1'b0;
    req_enable  = '1;
    req_valid   = '0;
    req_address = '0;
    req_id      = '0;
    for (int i = 0; i < N; i++) begin
      set_req(i, 16'(16'h0100 + i), 4'(i + 1));
    end
    test_reset;
    test_burst_rotation;
    test_back_to_back;
    test_stall_hold;
    test_mask_mid_burst;
    test_drain;
    test_pure_rr;
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
